// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types and constants for the instruction memory block
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BLOCK_BYTES = 16;
  localparam int OFFSET_W    = 4;

  localparam logic [127:0] READDATA_RST = '0;

endpackage

// File: rtl/inst_mem_prefetch_buf.sv
// rtl/inst_mem_prefetch_buf.sv - one-line next-block prefetch buffer with background latency counter
module inst_mem_prefetch_buf
  import inst_mem_pkg::*;
#(
  parameter int READ_LATENCY = 4,
  parameter int ADDR_W       = 6,
  parameter int BLOCK_W      = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  start_addr_i,
  input  logic               abort_i,
  input  logic [BLOCK_W-1:0] line_i,
  input  logic [ADDR_W-1:0]  address_i,
  output logic [ADDR_W-1:0]  pf_addr_o,
  output logic [BLOCK_W-1:0] pf_data_o,
  output logic               hit_o,
  output logic               pending_o,
  output logic               done_o
);

  logic               pf_valid_q;
  logic               pf_busy_q;
  logic [ADDR_W-1:0]  pf_addr_q;
  logic [BLOCK_W-1:0] pf_data_q;
  logic [3:0]         pf_cnt_q;

  assign pf_addr_o = pf_addr_q;
  assign pf_data_o = pf_data_q;
  assign done_o    = pf_busy_q && (pf_cnt_q == 4'd0);
  assign hit_o     = pf_valid_q && (pf_addr_q == address_i);
  assign pending_o = pf_busy_q && (pf_addr_q == address_i);

  always_ff @(posedge clock) begin
    if (!reset) begin
      pf_valid_q <= 1'b0;
      pf_busy_q  <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      pf_cnt_q   <= 4'd0;
    end else if (abort_i) begin
      pf_valid_q <= 1'b0;
      pf_busy_q  <= 1'b0;
    end else if (start_i) begin
      pf_valid_q <= 1'b0;
      pf_busy_q  <= 1'b1;
      pf_addr_q  <= start_addr_i;
      pf_cnt_q   <= 4'(READ_LATENCY - 1);
    end else if (pf_busy_q) begin
      if (pf_cnt_q == 4'd0) begin
        pf_data_q  <= line_i;
        pf_valid_q <= 1'b1;
        pf_busy_q  <= 1'b0;
      end else begin
        pf_cnt_q <= pf_cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/inst_mem_block.sv
// rtl/inst_mem_block.sv - block-addressed instruction memory with fixed-latency read/busywait handshake
// Optional next-line prefetch buffer is built when INST_MEM_PREFETCH_EN is defined.
module inst_mem_block
  import inst_mem_pkg::*;
#(
  parameter int READ_LATENCY = 4,
  parameter int ADDR_W       = 6,
  parameter int BLOCK_W      = 128
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         read,
  input  logic [ADDR_W-1:0]            address,
  output logic [BLOCK_W-1:0]           readdata,
  output logic                         busywait,
  input  logic                         load_en,
  input  logic [ADDR_W+OFFSET_W-1:0]   load_addr,
  input  logic [7:0]                   load_byte
);

  localparam int         BYTE_AW  = ADDR_W + OFFSET_W;
  localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

  logic [7:0]         mem_q [2**BYTE_AW];
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] readdata_q, readdata_d;
  logic [BLOCK_W-1:0] line;
  logic               load_accept;

  assign load_accept = reset && load_en && !read && (state_q == ST_IDLE);
  assign busywait    = reset && (((state_q == ST_IDLE) && read) || (state_q == ST_BUSY));
  assign readdata    = readdata_q;

  always_ff @(posedge clock) begin
    if (load_accept) mem_q[load_addr] <= load_byte;
  end

  // Little-endian line: byte {addr,0} lands in bits [7:0].
  always_comb begin
    line = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) line[i*8 +: 8] = mem_q[{addr_q, OFFSET_W'(i)}];
  end

`ifdef INST_MEM_PREFETCH_EN
  logic               pf_hit, pf_pending, pf_done, pf_abort;
  logic               pf_wait_q, pf_wait_d;
  logic [ADDR_W-1:0]  pf_addr;
  logic [BLOCK_W-1:0] pf_data, pf_line;

  always_comb begin
    pf_line = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) pf_line[i*8 +: 8] = mem_q[{pf_addr, OFFSET_W'(i)}];
  end

  assign pf_abort = load_accept ||
                    (reset && (state_q == ST_IDLE) && read && !pf_hit && !pf_pending);

  inst_mem_prefetch_buf #(
    .READ_LATENCY (READ_LATENCY),
    .ADDR_W       (ADDR_W),
    .BLOCK_W      (BLOCK_W)
  ) u_prefetch (
    .clock        (clock),
    .reset        (reset),
    .start_i      (state_q == ST_DONE),
    .start_addr_i (addr_q + ADDR_W'(1)),
    .abort_i      (pf_abort),
    .line_i       (pf_line),
    .address_i    (address),
    .pf_addr_o    (pf_addr),
    .pf_data_o    (pf_data),
    .hit_o        (pf_hit),
    .pending_o    (pf_pending),
    .done_o       (pf_done)
  );

  always_ff @(posedge clock) begin
    if (!reset) pf_wait_q <= 1'b0;
    else        pf_wait_q <= pf_wait_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    readdata_d = readdata_q;
`ifdef INST_MEM_PREFETCH_EN
    pf_wait_d  = pf_wait_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (read) begin
          addr_d  = address;
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
`ifdef INST_MEM_PREFETCH_EN
          if (pf_hit) begin
            readdata_d = pf_data;
            state_d    = ST_DONE;
          end else if (pf_pending && pf_done) begin
            readdata_d = pf_line;
            state_d    = ST_DONE;
          end else if (pf_pending) begin
            pf_wait_d = 1'b1;
          end
`endif
        end
      end
      ST_BUSY: begin
`ifdef INST_MEM_PREFETCH_EN
        if (pf_wait_q) begin
          if (pf_done) begin
            readdata_d = pf_line;
            state_d    = ST_DONE;
            pf_wait_d  = 1'b0;
          end
        end else
`endif
        if (cnt_q == 4'd0) begin
          readdata_d = line;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      readdata_q <= BLOCK_W'(READDATA_RST);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      readdata_q <= readdata_d;
    end
  end

endmodule
